spi_req_arbiter: RTL and testbench

- Shares one SPI master transaction port (spi_start / spi_data / spi_finish) between NUM_REQ independent requesters, e.g. the power-up register sequencer plus runtime register writers.
- Fair round-robin grant, one word per transaction.
- Enforces a minimum chip-select gap between transactions.
- Bounds each transaction with a finish timeout; reports completion per requester.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/spi_req_arbiter.sv | 134 +++++++++++++
 tb/tb_spi_req_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI request arbiter: FSM encoding (4-bit, same as
// the other SPI control blocks), default widths and the idle bus word.
package spi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'h0,
        ST_START = 4'h1,
        ST_WAIT  = 4'h2,
        ST_GAP   = 4'h3
    } spi_state_t;

    localparam int SPI_DATA_WIDTH     = 16;
    localparam int SPI_GAP_CYCLES_DEF = 1000;

    localparam logic [SPI_DATA_WIDTH-1:0] SPI_DATA_IDLE = '1;

    // A gap of zero would let two chip-select windows touch, so clamp it to one cycle.
    function automatic int spi_gap_eff(input int gap);
        return (gap < 1) ? 1 : gap;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search over a request vector with a registered priority
// pointer that moves one past the winner whenever the owner accepts a grant.
module rr_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_winner;
    logic             w_found;
    int               w_idx;

    // First set request at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
        end
    end

    assign winner  = w_winner;
    assign any_req = w_found;

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master transaction port between NUM_REQ requesters with
// round-robin grant, a minimum inter-transaction gap and a finish timeout.
module spi_req_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = SPI_DATA_WIDTH,
    parameter int GAP_CYCLES     = SPI_GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int GW             = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            err,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          spi_start,
    output logic [DATA_WIDTH-1:0]         spi_data,
    input  logic                          spi_finish
);

    localparam logic [31:0] GAP_LAST = 32'(spi_gap_eff(GAP_CYCLES));
    localparam bit          TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] TO_LAST  = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    spi_state_t r_state;
    spi_state_t w_state_next;

    logic [31:0]           r_cnt;
    logic [NUM_REQ-1:0]    r_ack;
    logic [NUM_REQ-1:0]    r_err;
    logic [GW-1:0]         r_grant_id;
    logic                  r_busy;
    logic                  r_spi_start;
    logic [DATA_WIDTH-1:0] r_spi_data;

    logic [NUM_REQ-1:0]    w_ack_next;
    logic [NUM_REQ-1:0]    w_err_next;
    logic                  w_start_next;
    logic                  w_advance;
    logic [GW-1:0]         w_winner;
    logic                  w_any_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GW)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (w_advance),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    // GAP holds until the counter reaches GAP_LAST, so it spans GAP_LAST+1 cycles
    // and the next start lands GAP_CYCLES+2 cycles after the ack pulse.
    always_comb begin
        w_state_next = r_state;
        w_ack_next   = '0;
        w_err_next   = '0;
        w_start_next = 1'b0;
        w_advance    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_advance    = 1'b1;
                    w_start_next = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (spi_finish) begin
                    w_ack_next[r_grant_id] = 1'b1;
                    w_state_next           = ST_GAP;
                end else if (TO_EN && (r_cnt == TO_LAST)) begin
                    w_ack_next[r_grant_id] = 1'b1;
                    w_err_next[r_grant_id] = 1'b1;
                    w_state_next           = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cnt >= GAP_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_err       <= '0;
            r_grant_id  <= '0;
            r_busy      <= 1'b0;
            r_spi_start <= 1'b0;
            r_spi_data  <= {DATA_WIDTH{SPI_DATA_IDLE[0]}};
        end else begin
            r_state     <= w_state_next;
            r_ack       <= w_ack_next;
            r_err       <= w_err_next;
            r_spi_start <= w_start_next;
            r_busy      <= (w_state_next != ST_IDLE);
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_advance) begin
                r_grant_id <= w_winner;
                r_spi_data <= req_data[w_winner*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign grant_id  = r_grant_id;
    assign busy      = r_busy;
    assign spi_start = r_spi_start;
    assign spi_data  = r_spi_data;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: reset, single transfer, round-robin order
// and spacing, wrap-around, timeout, spurious finish and mid-transaction reset.
module tb_spi_req_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int GAP = 4;
    localparam int TO  = 50;

    logic           clk;
    logic           rst_n;
    logic [NR-1:0]  reqLines;
    logic [NR*DW-1:0] reqData;
    logic [NR-1:0]  ack;
    logic [NR-1:0]  err;
    logic [1:0]     grantId;
    logic           busy;
    logic           spiStart;
    logic [DW-1:0]  spiData;
    logic           spiFinish;

    int numCompared;
    int numMismatched;

    spi_req_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (reqLines),
        .req_data   (reqData),
        .ack        (ack),
        .err        (err),
        .grant_id   (grantId),
        .busy       (busy),
        .spi_start  (spiStart),
        .spi_data   (spiData),
        .spi_finish (spiFinish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_start(input int maxc, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < maxc && !ok) begin
            @(negedge clk);
            n++;
            if (spiStart === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_ack(input int maxc, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < maxc && !ok) begin
            @(negedge clk);
            n++;
            if (ack !== '0) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < maxc && !ok) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0) ok = 1'b1;
        end
    endtask

    // Drive spi_finish for one cycle; returns at the negedge where ack is visible.
    task automatic pulse_finish();
        spiFinish = 1'b1;
        @(negedge clk);
        spiFinish = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        numCompared++;
        if ({spiStart, busy, ack, err, grantId, spiData} !== {1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 16'hFFFF}) begin
            numMismatched++;
            $display("[TB] FAIL reset_state: got start=%b busy=%b ack=%b err=%b gid=%0d data=%h, want 0 0 0000 0000 0 ffff",
                     spiStart, busy, ack, err, grantId, spiData);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit bad;
        bit ok;
        reqData[15:0] = 16'h0E00;
        reqLines = 4'b0001;
        @(negedge clk);
        numCompared++;
        if ({spiStart, grantId, spiData} !== {1'b1, 2'd0, 16'h0E00}) begin
            numMismatched++;
            $display("[TB] FAIL single_start: got start=%b gid=%0d data=%h, want 1 0 0e00", spiStart, grantId, spiData);
        end
        bad = 1'b0;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (spiStart !== 1'b0 || ack !== 4'h0 || spiData !== 16'h0E00 || busy !== 1'b1) bad = 1'b1;
        end
        numCompared++;
        if (bad) begin
            numMismatched++;
            $display("[TB] FAIL single_hold: got start=%b ack=%b data=%h busy=%b, want 0 0000 0e00 1", spiStart, ack, spiData, busy);
        end
        @(negedge clk);
        pulse_finish();
        reqLines = 4'b0000;
        numCompared++;
        if ({ack, err} !== {4'b0001, 4'b0000}) begin
            numMismatched++;
            $display("[TB] FAIL single_ack: got ack=%b err=%b, want 0001 0000", ack, err);
        end
        @(negedge clk);
        numCompared++;
        if (ack !== 4'b0000) begin
            numMismatched++;
            $display("[TB] FAIL single_ack_width: got ack=%b, want 0000", ack);
        end
        wait_idle(20, ok);
        numCompared++;
        if (!ok) begin
            numMismatched++;
            $display("[TB] FAIL single_idle: got busy=%b, want 0 within 20 cycles", busy);
        end
    endtask

    task automatic test_round_robin();
        int expSeq[5] = '{0, 1, 2, 3, 0};
        logic [3:0] expAck;
        int n;
        bit ok;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) reqData[i*DW +: DW] = 16'hA000 + 16'(i);
        reqLines = 4'b1111;
        wait_start(5, n, ok);
        numCompared++;
        if (!ok) begin
            numMismatched++;
            $display("[TB] FAIL rr_first_start: got no spi_start, want one within 5 cycles");
        end
        for (int t = 0; t < 5; t++) begin
            numCompared++;
            if ({grantId, spiData} !== {2'(expSeq[t]), 16'hA000 + 16'(expSeq[t])}) begin
                numMismatched++;
                $display("[TB] FAIL rr_grant_%0d: got gid=%0d data=%h, want %0d %h",
                         t, grantId, spiData, expSeq[t], 16'hA000 + 16'(expSeq[t]));
            end
            repeat (2) @(negedge clk);
            pulse_finish();
            expAck = 4'b0001 << expSeq[t];
            numCompared++;
            if ({ack, err} !== {expAck, 4'b0000}) begin
                numMismatched++;
                $display("[TB] FAIL rr_ack_%0d: got ack=%b err=%b, want %b 0000", t, ack, err, expAck);
            end
            if (t == 4) begin
                reqLines = 4'b0000;
            end else begin
                wait_start(30, n, ok);
                numCompared++;
                if (!ok || n != GAP + 2) begin
                    numMismatched++;
                    $display("[TB] FAIL rr_spacing_%0d: got found=%b after %0d cycles, want start %0d cycles after ack",
                             t, ok, n, GAP + 2);
                end
            end
        end
        wait_idle(20, ok);
    endtask

    task automatic test_wrap();
        int n;
        bit ok;
        reqLines = 4'b0100;
        wait_start(5, n, ok);
        numCompared++;
        if (!ok || grantId !== 2'd2) begin
            numMismatched++;
            $display("[TB] FAIL wrap_setup: got found=%b gid=%0d, want 1 2", ok, grantId);
        end
        repeat (2) @(negedge clk);
        pulse_finish();
        reqLines = 4'b0000;
        wait_idle(20, ok);
        reqLines = 4'b1001;
        wait_start(5, n, ok);
        numCompared++;
        if (!ok || grantId !== 2'd3 || spiData !== 16'hA003) begin
            numMismatched++;
            $display("[TB] FAIL wrap_first: got found=%b gid=%0d data=%h, want 1 3 a003", ok, grantId, spiData);
        end
        repeat (2) @(negedge clk);
        pulse_finish();
        reqLines = 4'b0001;
        wait_start(30, n, ok);
        numCompared++;
        if (!ok || grantId !== 2'd0 || spiData !== 16'hA000) begin
            numMismatched++;
            $display("[TB] FAIL wrap_second: got found=%b gid=%0d data=%h, want 1 0 a000", ok, grantId, spiData);
        end
        repeat (2) @(negedge clk);
        pulse_finish();
        reqLines = 4'b0000;
        wait_idle(20, ok);
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        reqLines = 4'b0010;
        wait_start(5, n, ok);
        numCompared++;
        if (!ok || grantId !== 2'd1) begin
            numMismatched++;
            $display("[TB] FAIL to_grant: got found=%b gid=%0d, want 1 1", ok, grantId);
        end
        wait_ack(70, n, ok);
        numCompared++;
        if (!ok || n != TO + 1 || ack !== 4'b0010 || err !== 4'b0010) begin
            numMismatched++;
            $display("[TB] FAIL to_abort: got found=%b after %0d cycles ack=%b err=%b, want 1 %0d 0010 0010",
                     ok, n, ack, err, TO + 1);
        end
        reqLines = 4'b0000;
        pulse_finish();
        numCompared++;
        if (ack !== 4'b0000 || busy !== 1'b1) begin
            numMismatched++;
            $display("[TB] FAIL spur_gap: got ack=%b busy=%b, want 0000 1", ack, busy);
        end
        wait_idle(20, ok);
        pulse_finish();
        @(negedge clk);
        numCompared++;
        if (ack !== 4'b0000 || busy !== 1'b0 || spiStart !== 1'b0) begin
            numMismatched++;
            $display("[TB] FAIL spur_idle: got ack=%b busy=%b start=%b, want 0000 0 0", ack, busy, spiStart);
        end
    endtask

    task automatic test_finish_on_timeout();
        int n;
        bit ok;
        reqLines = 4'b0100;
        wait_start(5, n, ok);
        numCompared++;
        if (!ok || grantId !== 2'd2) begin
            numMismatched++;
            $display("[TB] FAIL to_next_served: got found=%b gid=%0d, want 1 2", ok, grantId);
        end
        repeat (TO) @(negedge clk);
        pulse_finish();
        numCompared++;
        if (ack !== 4'b0100 || err !== 4'b0000) begin
            numMismatched++;
            $display("[TB] FAIL finish_wins: got ack=%b err=%b, want 0100 0000", ack, err);
        end
        reqLines = 4'b0000;
        wait_idle(20, ok);
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        bit sawAck;
        reqData[15:0] = 16'h1234;
        reqLines = 4'b0001;
        wait_start(5, n, ok);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        sawAck = (ack !== 4'b0000);
        numCompared++;
        if ({spiStart, busy, grantId, spiData} !== {1'b0, 1'b0, 2'd0, 16'hFFFF} || sawAck) begin
            numMismatched++;
            $display("[TB] FAIL reset_mid: got start=%b busy=%b gid=%0d data=%h ack=%b, want 0 0 0 ffff 0000",
                     spiStart, busy, grantId, spiData, ack);
        end
        rst_n = 1'b1;
        @(negedge clk);
        numCompared++;
        if ({spiStart, grantId, spiData} !== {1'b1, 2'd0, 16'h1234}) begin
            numMismatched++;
            $display("[TB] FAIL reset_regrant: got start=%b gid=%0d data=%h, want 1 0 1234", spiStart, grantId, spiData);
        end
        repeat (2) @(negedge clk);
        pulse_finish();
        numCompared++;
        if (ack !== 4'b0001) begin
            numMismatched++;
            $display("[TB] FAIL reset_regrant_ack: got ack=%b, want 0001", ack);
        end
        reqLines = 4'b0000;
        wait_idle(20, ok);
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        rst_n     = 1'b0;
        reqLines  = '0;
        reqData   = '0;
        spiFinish = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_finish_on_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
